// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble, one bit per clock).
// Define BIN2BCD_SAT_EN to saturate over-range results to 9999; otherwise the value is reduced mod 10000.
module bin2bcd_seq (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic [13:0] bin_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [13:0] bin_reg;
    logic [15:0] acc_reg;
    logic [3:0]  cnt_reg;
    logic        carry_reg;
    logic [15:0] acc_adj;

    // Per-digit correction applied before each shift so a digit >= 5 carries into the next one.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dabble
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                        acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge CLK_50M or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg   <= bin_in;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        carry_reg <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bit leaving the thousands digit is a carry into the 10^4 place.
                    carry_reg <= carry_reg | acc_adj[15];
                    acc_reg   <= {acc_adj[14:0], bin_reg[13]};
                    bin_reg   <= {bin_reg[12:0], 1'b0};
                    cnt_reg   <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd13) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
`ifdef BIN2BCD_SAT_EN
                    bcd_out <= carry_reg ? 16'h9999 : acc_reg;
`else
                    bcd_out <= acc_reg;
`endif
                    ovf       <= carry_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic [13:0] bin_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    bin2bcd_seq dut (
        .CLK_50M (clk),
        .RST     (rst),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected {ovf, bcd} from decimal arithmetic on the operand.
    function automatic logic [16:0] model(input int v);
        int r;
        logic [15:0] b;
        logic o;
        o = (v > 9999);
`ifdef BIN2BCD_SAT_EN
        r = o ? 9999 : v;
`else
        r = v % 10000;
`endif
        b[15:12] = 4'((r / 1000) % 10);
        b[11:8]  = 4'((r / 100) % 10);
        b[7:4]   = 4'((r / 10) % 10);
        b[3:0]   = 4'(r % 10);
        return {o, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion from edge k to k+15. Leaves start high when hold is set;
    // bin_in is changed to v_mid during SHIFT to prove the operand is latched.
    task automatic do_conv(input int v, input bit hold, input int v_mid);
        logic [16:0] exp;
        exp    = model(v);
        bin_in = 14'(v);
        start  = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("busy_k", busy, 1);
        check("done_k", done, 0);
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) bin_in = 14'(v_mid);
            tick();
            check($sformatf("busy_k+%0d", i), busy, 1);
            check($sformatf("done_k+%0d", i), done, 0);
        end
        tick();
        check("done_k+15", done, 1);
        check("busy_k+15", busy, 0);
        check($sformatf("bcd v=%0d", v), bcd_out, exp[15:0]);
        check($sformatf("ovf v=%0d", v), ovf, exp[16]);
        $display("conv v=%0d bcd=%04h ovf=%0b", v, bcd_out, ovf);
    endtask

    initial begin
        logic [15:0] held;
        logic        held_ovf;
        int          v;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #25;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Start accepted on the very first edge after release.
        do_conv(1234, 0, 1234);
        do_conv(0, 0, 0);
        do_conv(9999, 0, 9999);
        do_conv(12345, 0, 12345);
        do_conv(10000, 0, 10000);
        do_conv(16383, 0, 16383);

        // Start held high, operand changed mid-conversion.
        do_conv(500, 1, 42);
        do_conv(42, 1, 42);
        start = 1'b0;
        tick();
        check("hold_done_clear", done, 0);

        for (int n = 0; n < 25; n++) begin
            v = int'($urandom_range(0, 16383));
            do_conv(v, 0, int'($urandom_range(0, 16383)));
            held     = bcd_out;
            held_ovf = ovf;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                bin_in = 14'($urandom_range(0, 16383));
                tick();
                check("idle_done", done, 0);
                check("idle_bcd_hold", bcd_out, held);
                check("idle_ovf_hold", ovf, held_ovf);
            end
        end

        // Reset at edge k+7 of a conversion of 8765.
        do_conv(1234, 0, 1234);
        bin_in = 14'd8765;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        @(posedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", bcd_out, 0);
        check("abort_ovf", ovf, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_abort_done", done, 0);
            check("post_abort_bcd", bcd_out, 0);
        end
        do_conv(int'($urandom_range(0, 16383)), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have port CLK_50M, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port bin_in, input, 14 bits: unsigned binary value to convert (0..16383).
REQ-004 SHALL have port start, input, 1 bit: conversion request, sampled on rising edge.
REQ-005 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse marking a new bcd_out.
REQ-007 SHALL have port bcd_out, output, 16 bits: packed BCD result [15:12]=thousands .. [3:0]=units; feeds the 4-digit 7-segment display data input.
REQ-008 SHALL have port ovf, output, 1 bit: high when the last converted value exceeded 9999.

Function
REQ-009 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-010 SHALL, in IDLE with start=1 at edge k, capture bin_in into a 14-bit shift register, clear a 16-bit BCD accumulator and iteration counter, set busy=1 and enter SHIFT.
REQ-011 SHALL, in IDLE with start=0, hold all outputs.
REQ-012 SHALL, in SHIFT, per edge: add 3 to every accumulator nibble >=5, then shift {accumulator, shift register} left by one bit (double-dabble); exactly 14 iterations, edges k+1..k+14.
REQ-013 SHALL record that any bit shifted out of accumulator bit 15 (weight 10^4) indicates overflow.
REQ-014 SHALL enter DONE after the 14th iteration (edge k+14).
REQ-015 SHALL, in DONE at edge k+15: load bcd_out and ovf, set done=1 for exactly one cycle, clear busy, return to IDLE.
REQ-016 SHALL give latency start-edge to done-edge of 15 clocks; earliest next accepted start at edge k+16.
REQ-017 SHALL ignore start while in SHIFT or DONE; no queuing, captured operand unaffected by bin_in changes.
REQ-018 SHALL hold bcd_out and ovf stable between done pulses.
REQ-019 SHALL keep every bcd_out nibble in 0..9 for all inputs.

Reset
REQ-020 SHALL on RST=0, regardless of state, immediately force: state IDLE, busy=0, done=0, ovf=0, bcd_out=16'h0000, accumulator, shift register and counter cleared.
REQ-021 SHALL abort an in-flight conversion on reset with no done pulse and no partial result visible.
REQ-022 SHALL accept a start on the first rising edge after RST deasserts.

Configuration
REQ-023 SHALL use macro BIN2BCD_SAT_EN to select over-range handling.
REQ-024 SHALL, with BIN2BCD_SAT_EN defined, load bcd_out=16'h9999 and ovf=1 when the captured value >9999.
REQ-025 SHALL, without BIN2BCD_SAT_EN, load bcd_out=BCD(value mod 10000) and ovf=1 when value >9999.
REQ-026 SHALL load ovf=0 and the exact BCD result for values <=9999 in both builds.

Verification
REQ-027 SHALL test: bin_in=1234, start pulse at edge k -> busy edges k..k+15, done one cycle at k+15, bcd_out=16'h1234, ovf=0.
REQ-028 SHALL test: bin_in=0 then bin_in=9999 back-to-back (second start at k+16) -> 16'h0000 then 16'h9999, ovf=0 both.
REQ-029 SHALL test: bin_in=12345 -> ovf=1; bcd_out=16'h9999 with BIN2BCD_SAT_EN, 16'h2345 without.
REQ-030 SHALL test: start held high with bin_in changed to 42 during SHIFT after starting with 500 -> single result 16'h0500; next conversion (start still high) begins k+16 yields 16'h0042.
REQ-031 SHALL test: RST low at edge k+7 of a conversion of 8765 -> busy=0, done=0, bcd_out=16'h0000 immediately; no done pulse after release.
